update_scheduler: RTL and testbench
===================================

Name: update_scheduler

Overview:
- Per-frame sequencer for the game-logic datapath.
- On each vertical-blank entry it issues one-cycle start strobes, one at a time in fixed order, to the entity update units (player, hecatia, moon, laser), waiting for each unit's done.
- After all units finish, it strobes the collision/hit judges and then raises frame_tick.
- Sits between the VGA row counter, the FSM's game_en, and the entity/judge units. Entities therefore see a consistent, race-free update order once per frame.

Parameters:
NUM_UNITS, 4, number of sequenced update units; index 0 is serviced first.
V_ACTIVE, 480, row address at which vertical blank begins.
TIMEOUT, 1023, maximum cycles to wait for any single done before forcing progress.
FRAME_DIV, 1, run a sequence every FRAME_DIV-th vblank entry (1..15).

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
game_en  in  1  gameplay enable from FSM; sampled at vblank entry only
y  in  10  current VGA row address
unit_mask  in  NUM_UNITS  1 = unit participates this frame, 0 = skipped
start  out  NUM_UNITS  one-hot single-cycle start strobe to update units
done  in  NUM_UNITS  per-unit completion pulse or level
judge_start  out  1  single-cycle strobe to collision/hit judges
judge_done  in  1  judges finished
frame_tick  out  1  single-cycle pulse when the whole sequence completes
busy  out  1  high from sequence launch until frame_tick
cur_unit  out  3  index of unit currently dispatched/awaited
timeout_err  out  1  sticky: some wait hit TIMEOUT
overrun  out  1  sticky: vblank entry arrived while busy

Behaviour:
- Reset (synchronous, clk edge with reset=1): state IDLE. Zero: start, judge_start, frame_tick, busy, cur_unit, timeout_err, overrun, frame divider, timeout counter, previous-y register. An active sequence is abandoned immediately; no strobes are issued in the reset cycle.
- Vblank entry: a registered y_prev is kept. The event fires in the cycle where y==V_ACTIVE and y_prev!=V_ACTIVE. Detection latency is 1 cycle after y changes.
- Divider: a 4-bit counter increments on each vblank entry. A sequence launches only when counter==FRAME_DIV-1 (counter then clears) and game_en==1. If game_en==0, the counter holds at 0.
- States:
  - IDLE: on launch, set busy=1, cur_unit=0, go SELECT.
  - SELECT: if cur_unit==NUM_UNITS go JUDGE. Else if unit_mask[cur_unit]==0, increment cur_unit and stay in SELECT (1 cycle per skipped unit). Else assert start[cur_unit] for exactly this one cycle, clear the timeout counter, go WAIT.
  - WAIT: on done[cur_unit]==1, increment cur_unit and go SELECT. Else if the timeout counter reaches TIMEOUT, set timeout_err, increment cur_unit, go SELECT. done is ignored in the cycle start is high. done of non-current units is ignored.
  - JUDGE: assert judge_start for 1 cycle, clear the timeout counter, go JWAIT.
  - JWAIT: on judge_done, or on timeout (which sets timeout_err), go FINISH.
  - FINISH: frame_tick=1 for 1 cycle, busy=0, return to IDLE.
- Minimum sequence latency, with all units masked in and done returned the cycle after start: 2*NUM_UNITS + 4 cycles from vblank-entry detection to frame_tick.
- All units masked: SELECT walks NUM_UNITS cycles, then JUDGE runs normally.
- Vblank entry while busy: overrun set (sticky); the event is discarded and not queued; the divider still counts.
- unit_mask is sampled per unit in SELECT, so a mid-sequence change affects only units not yet reached.
- game_en falling mid-sequence: no effect. The sequence completes so that entity state stays consistent.
- Sticky flags clear only on reset.
- The timeout counter is 10 bits and saturates; it never wraps.

Optional Feature:
- UPDATE_SCHED_STATS_EN:
  - Defined: adds output max_cycles[15:0]. A cycle counter runs while busy and saturates at 16'hFFFF. At FINISH, if count>max_cycles, max_cycles is updated in the same cycle as frame_tick. max_cycles resets to 0.
  - Undefined: the port and counter are absent, and all other behaviour is identical.

Decomposition:
- Shared package (game_pkg): state encoding (IDLE, SELECT, WAIT, JUDGE, JWAIT, FINISH as a 3-bit enum), V_ACTIVE default, timeout width constant.
- One sub-module, vblank_edge_detect: y_prev register and comparator producing a single-cycle vblank_entry pulse. Reused by other frame-rate blocks.

Test Plan:
- Reset, then y stepped 479→480 with game_en=1, unit_mask=4'b1111, each done returned 1 cycle after its start → start pulses 0001,0010,0100,1000 in order; judge_start follows; frame_tick 12 cycles after detection; busy low afterwards.
- unit_mask=4'b0101 → only start[0] and start[2] pulse; cur_unit passes 1 and 3 without strobes; frame_tick still produced.
- done[1] held low → after 1023 wait cycles timeout_err=1, start[2] issued next, sequence completes.
- Second y 479→480 edge while stalled in WAIT → overrun=1, no second sequence launched; frame_tick count stays 1.
- FRAME_DIV=2, three vblank entries → launches on the 2nd only; game_en=0 at an edge → no launch.
- reset asserted during WAIT on unit 2 → next cycle all outputs 0, state IDLE; the next vblank restarts from unit 0.

Source files
------------

// File: rtl/game_pkg.sv
// Shared definitions for the frame-rate game-logic blocks: sequencer state
// encoding, the default vblank row and the wait-timeout counter width.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_WAIT   = 3'd2,
        ST_JUDGE  = 3'd3,
        ST_JWAIT  = 3'd4,
        ST_FINISH = 3'd5
    } state_t;

    localparam int V_ACTIVE_DEF = 480;
    localparam int TMO_W        = 10;

endpackage

// File: rtl/vblank_edge_detect.sv
// Single-cycle pulse in the first cycle the VGA row counter sits on V_ACTIVE.
// The previous row is registered, so the pulse is combinational on the current row.
module vblank_edge_detect
    import game_pkg::*;
#(
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] y,
    output logic       vblank_entry
);

    localparam logic [9:0] V_ROW = 10'(V_ACTIVE);

    logic [9:0] y_prev_q;
    logic [9:0] y_prev_d;

    always_comb begin
        y_prev_d     = y;
        vblank_entry = (y == V_ROW) && (y_prev_q != V_ROW);
    end

    always_ff @(posedge clk) begin
        if (reset) y_prev_q <= '0;
        else       y_prev_q <= y_prev_d;
    end

endmodule

// File: rtl/update_scheduler.sv
// Per-frame sequencer: on vblank entry strobes each entity unit in order, then the
// judges, then pulses frame_tick. Define UPDATE_SCHED_STATS_EN to add max_cycles.
module update_scheduler
    import game_pkg::*;
#(
    parameter int NUM_UNITS = 4,
    parameter int V_ACTIVE  = V_ACTIVE_DEF,
    parameter int TIMEOUT   = 1023,
    parameter int FRAME_DIV = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 game_en,
    input  logic [9:0]           y,
    input  logic [NUM_UNITS-1:0] unit_mask,
    output logic [NUM_UNITS-1:0] start,
    input  logic [NUM_UNITS-1:0] done,
    output logic                 judge_start,
    input  logic                 judge_done,
    output logic                 frame_tick,
    output logic                 busy,
    output logic [2:0]           cur_unit,
    output logic                 timeout_err,
    output logic                 overrun,
    output logic [2:0]           state_dbg
`ifdef UPDATE_SCHED_STATS_EN
    ,
    output logic [15:0]          max_cycles
`endif
);

    // Handshake: start[i] / judge_start are one-cycle strobes issued from SELECT /
    // JUDGE; done[i] / judge_done are only looked at in the following WAIT / JWAIT
    // cycles, so either a pulse or a held level is accepted.
    localparam logic [NUM_UNITS-1:0] UNIT0     = {{(NUM_UNITS-1){1'b0}}, 1'b1};
    localparam logic [2:0]           CUR_END   = 3'(NUM_UNITS);
    localparam logic [3:0]           DIV_LAST  = 4'(FRAME_DIV - 1);
    localparam logic [TMO_W-1:0]     TMO_LIMIT = TMO_W'(TIMEOUT);

    state_t             state_q, state_d;
    logic [2:0]         cur_q, cur_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic [3:0]         div_q, div_d;
    logic               terr_q, terr_d;
    logic               ovr_q, ovr_d;
    logic               vblank_entry;
    logic               launch;
    logic [NUM_UNITS-1:0] cur_onehot;
    logic               cur_sel;
    logic               cur_done;

    vblank_edge_detect #(
        .V_ACTIVE(V_ACTIVE)
    ) u_vblank (
        .clk         (clk),
        .reset       (reset),
        .y           (y),
        .vblank_entry(vblank_entry)
    );

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        tmo_d       = tmo_q;
        div_d       = div_q;
        terr_d      = terr_q;
        ovr_d       = ovr_q;
        start       = '0;
        judge_start = 1'b0;
        frame_tick  = 1'b0;

        cur_onehot = UNIT0 << cur_q;
        cur_sel    = |(unit_mask & cur_onehot);
        cur_done   = |(done & cur_onehot);
        launch     = vblank_entry && game_en && (div_q == DIV_LAST) && (state_q == ST_IDLE);

        // The divider keeps counting even when the event itself is dropped as an overrun.
        if (vblank_entry) begin
            if (state_q != ST_IDLE) ovr_d = 1'b1;
            if (!game_en)               div_d = '0;
            else if (div_q == DIV_LAST) div_d = '0;
            else                        div_d = div_q + 4'd1;
        end

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d = ST_SELECT;
                    cur_d   = '0;
                end
            end
            ST_SELECT: begin
                if (cur_q == CUR_END) begin
                    state_d = ST_JUDGE;
                end else if (!cur_sel) begin
                    cur_d = cur_q + 3'd1;
                end else begin
                    start   = cur_onehot;
                    tmo_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cur_done) begin
                    cur_d   = cur_q + 3'd1;
                    state_d = ST_SELECT;
                end else if (tmo_q == TMO_LIMIT) begin
                    terr_d  = 1'b1;
                    cur_d   = cur_q + 3'd1;
                    state_d = ST_SELECT;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_JUDGE: begin
                judge_start = 1'b1;
                tmo_d       = '0;
                state_d     = ST_JWAIT;
            end
            ST_JWAIT: begin
                if (judge_done) begin
                    state_d = ST_FINISH;
                end else if (tmo_q == TMO_LIMIT) begin
                    terr_d  = 1'b1;
                    state_d = ST_FINISH;
                end else if (tmo_q != '1) begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            ST_FINISH: begin
                frame_tick = 1'b1;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cur_q   <= '0;
            tmo_q   <= '0;
            div_q   <= '0;
            terr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            tmo_q   <= tmo_d;
            div_q   <= div_d;
            terr_q  <= terr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign busy        = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign cur_unit    = cur_q;
    assign timeout_err = terr_q;
    assign overrun     = ovr_q;
    assign state_dbg   = state_q;

`ifdef UPDATE_SCHED_STATS_EN
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] max_q, max_d;

    always_comb begin
        cyc_d = cyc_q;
        max_d = max_q;
        if (launch)                          cyc_d = '0;
        else if (busy && cyc_q != 16'hFFFF) cyc_d = cyc_q + 16'd1;
        if (state_q == ST_FINISH && cyc_q > max_q) max_d = cyc_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cyc_q <= '0;
            max_q <= '0;
        end else begin
            cyc_q <= cyc_d;
            max_q <= max_d;
        end
    end

    assign max_cycles = max_q;
`endif

endmodule

// File: tb/tb_update_scheduler.sv
// Directed bench for update_scheduler: ordered dispatch, masking, timeout, overrun,
// frame divider (second instance with FRAME_DIV=2), game_en gating and mid-sequence reset.
module tb_update_scheduler;
    import game_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       game_en = 1'b1;
    logic [9:0] y = '0;
    logic [3:0] unit_mask = 4'b1111;

    logic [3:0] start, done = '0;
    logic       judge_start, judge_done = 1'b0;
    logic       frame_tick, busy, timeout_err, overrun;
    logic [2:0] cur_unit, state_dbg;

    logic [3:0] start2, done2 = '0;
    logic       judge_start2, judge_done2 = 1'b0;
    logic       frame_tick2, busy2, timeout_err2, overrun2;
    logic [2:0] cur_unit2, state_dbg2;

`ifdef UPDATE_SCHED_STATS_EN
    logic [15:0] max_cycles, max_cycles2;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int ft_cnt = 0;
    logic [3:0] hold_mask = '0;
    logic [3:0] start_last = '0, start2_last = '0;
    logic       js_last = 1'b0, js2_last = 1'b0;

    update_scheduler #(.FRAME_DIV(1)) u_dut (
        .clk(clk), .reset(reset), .game_en(game_en), .y(y), .unit_mask(unit_mask),
        .start(start), .done(done), .judge_start(judge_start), .judge_done(judge_done),
        .frame_tick(frame_tick), .busy(busy), .cur_unit(cur_unit),
        .timeout_err(timeout_err), .overrun(overrun), .state_dbg(state_dbg)
`ifdef UPDATE_SCHED_STATS_EN
        , .max_cycles(max_cycles)
`endif
    );

    update_scheduler #(.FRAME_DIV(2)) u_dut2 (
        .clk(clk), .reset(reset), .game_en(game_en), .y(y), .unit_mask(unit_mask),
        .start(start2), .done(done2), .judge_start(judge_start2), .judge_done(judge_done2),
        .frame_tick(frame_tick2), .busy(busy2), .cur_unit(cur_unit2),
        .timeout_err(timeout_err2), .overrun(overrun2), .state_dbg(state_dbg2)
`ifdef UPDATE_SCHED_STATS_EN
        , .max_cycles(max_cycles2)
`endif
    );

    always #5 clk = ~clk;

    // Unit models: done is returned in the cycle right after start (unless held off).
    always @(negedge clk) begin
        done        = start_last & ~hold_mask;
        start_last  = start;
        judge_done  = js_last;
        js_last     = judge_start;
        done2       = start2_last;
        start2_last = start2;
        judge_done2 = js2_last;
        js2_last    = judge_start2;
        if (frame_tick) ft_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic step_to(input int target);
        while (cyc < target) step();
    endtask

    // Leaves the bench in the detection cycle with cyc = 0.
    task automatic vblank();
        y = 10'd479;
        step();
        y = 10'd480;
        cyc = 0;
    endtask

    initial begin
        logic [3:0] exp_start;
        logic [2:0] exp_cur;

        // Reset state
        step();
        step();
        reset = 1'b0;
        check("rst_start", start, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_cur", cur_unit, 3'd0);
        check("rst_terr", timeout_err, 1'b0);
        check("rst_ovr", overrun, 1'b0);
        check("rst_ft", frame_tick, 1'b0);
        check("rst_state", state_dbg, ST_IDLE);
        check("rst_busy2", busy2, 1'b0);

        // Full sequence, all units, done one cycle after start
        vblank();
        for (int c = 1; c <= 12; c++) begin
            step();
            exp_start = (c == 1) ? 4'b0001 : (c == 3) ? 4'b0010 :
                        (c == 5) ? 4'b0100 : (c == 7) ? 4'b1000 : 4'b0000;
            check("t1_start", start, exp_start);
            check("t1_judge", judge_start, c == 10);
            check("t1_ft", frame_tick, c == 12);
            check("t1_busy", busy, c <= 11);
            if (c == 1) check("fd_first_nolaunch", busy2, 1'b0);
        end
        step();
        check("t1_busy_after", busy, 1'b0);
        check("t1_idle_after", state_dbg, ST_IDLE);
        check("t1_ft_cnt", ft_cnt, 1);
`ifdef UPDATE_SCHED_STATS_EN
        check("t1_max_cycles", max_cycles, 16'd11);
`endif

        // Masked units 1 and 3 are walked without strobes
        unit_mask = 4'b0101;
        vblank();
        for (int c = 1; c <= 10; c++) begin
            step();
            exp_start = (c == 1) ? 4'b0001 : (c == 4) ? 4'b0100 : 4'b0000;
            exp_cur = (c <= 2) ? 3'd0 : (c == 3) ? 3'd1 : (c <= 5) ? 3'd2 :
                      (c == 6) ? 3'd3 : 3'd4;
            check("t2_start", start, exp_start);
            check("t2_cur", cur_unit, exp_cur);
            check("t2_judge", judge_start, c == 8);
            check("t2_ft", frame_tick, c == 10);
            if (c == 1) begin
                check("fd_second_launch", busy2, 1'b1);
                check("fd_second_start", start2, 4'b0001);
            end
            if (c == 10) check("fd_second_ft", frame_tick2, 1'b1);
        end

        // Unit 1 never answers -> timeout; a second vblank during the stall overruns
        unit_mask = 4'b1111;
        hold_mask = 4'b0010;
        vblank();
        step();
        check("fd_third_nolaunch", busy2, 1'b0);
        step_to(3);
        check("t3_start1", start, 4'b0010);
        check("t3_cur1", cur_unit, 3'd1);
        step_to(100);
        y = 10'd479;
        step();
        y = 10'd480;
        step();
        check("t4_overrun", overrun, 1'b1);
        check("t4_still_wait", state_dbg, ST_WAIT);
        check("t4_busy", busy, 1'b1);
        step_to(1027);
        check("t3_terr_before", timeout_err, 1'b0);
        check("t3_wait_before", state_dbg, ST_WAIT);
        check("t3_nostart_before", start, 4'b0000);
        step();
        check("t3_terr", timeout_err, 1'b1);
        check("t3_start2", start, 4'b0100);
        check("t3_cur2", cur_unit, 3'd2);
        step_to(1035);
        check("t3_ft", frame_tick, 1'b1);
        step();
        check("t4_ft_cnt", ft_cnt, 3);
        check("t4_ovr_sticky", overrun, 1'b1);
        check("t3_busy_after", busy, 1'b0);

        // game_en low at the vblank edge: no launch
        hold_mask = 4'b0000;
        game_en = 1'b0;
        vblank();
        step();
        check("t5_nolaunch_busy", busy, 1'b0);
        check("t5_nolaunch_state", state_dbg, ST_IDLE);
        step();
        check("t5_nostart", start, 4'b0000);
        game_en = 1'b1;

        // Reset while waiting on unit 2, then restart from unit 0
        hold_mask = 4'b0100;
        vblank();
        step_to(5);
        check("t6_start2", start, 4'b0100);
        step_to(8);
        check("t6_wait", state_dbg, ST_WAIT);
        check("t6_cur", cur_unit, 3'd2);
        reset = 1'b1;
        y = 10'd0;
        step();
        check("t6_rst_state", state_dbg, ST_IDLE);
        check("t6_rst_start", start, 4'b0000);
        check("t6_rst_busy", busy, 1'b0);
        check("t6_rst_cur", cur_unit, 3'd0);
        check("t6_rst_terr", timeout_err, 1'b0);
        check("t6_rst_ovr", overrun, 1'b0);
        check("t6_rst_judge", judge_start, 1'b0);
        check("t6_rst_ft", frame_tick, 1'b0);
        reset = 1'b0;
        hold_mask = 4'b0000;
        vblank();
        step();
        check("t6_restart_start", start, 4'b0001);
        check("t6_restart_cur", cur_unit, 3'd0);
        check("t6_restart_busy", busy, 1'b1);
        // game_en dropping mid-sequence does not stop it
        game_en = 1'b0;
        step_to(11);
        check("t6_no_early_ft", frame_tick, 1'b0);
        step();
        check("t6_ft", frame_tick, 1'b1);
        check("t6_terr_clear", timeout_err, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
